bcd_timer_counter: RTL

Parametrised N-digit BCD interval counter with a programmable terminal count, up/down mode, single-cycle carry pulse and optional remaining-count output. It generalises the two-digit fixed-radix counter used by the display timing chain: any digit count, either direction, validated limit loading, and one-shot or auto-reload operation. It sits between the enable-tick source and the seven-segment/VGA digit renderers, and chains through `C_OUT` into the next timer stage.

---
 rtl/bcd_timer_counter_pkg.sv | 33 +++
 rtl/bcd_timer_counter_if.sv | 35 +++
 rtl/bcd_timer_counter_digit_step.sv | 43 ++++
 rtl/bcd_timer_counter.sv | 133 +++++++++++++
 4 files changed

// File: rtl/bcd_timer_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_timer_counter_pkg
// Description : Shared constants, state encoding and BCD validity helper for
//               the BCD interval counter.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_timer_counter_pkg;

  localparam int         DIGIT_W   = 4;
  localparam logic [3:0] MAX_DIGIT = 4'd9;
  // Widest supported bus (8 digits); narrower buses are zero-extended.
  localparam int         MAX_BUS_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  // True when every nibble of the bus is a legal BCD digit. Zero padding of
  // unused upper digits is always legal, so one check covers every width.
  function automatic logic is_valid_bcd(input logic [MAX_BUS_W-1:0] bus);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < MAX_BUS_W / DIGIT_W; i++) begin
      if (bus[i*DIGIT_W +: DIGIT_W] > MAX_DIGIT) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_timer_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : bcd_timer_counter_if
// Description : Control/status bundle of the BCD interval counter.
//               REM_OUT exists only when BCD_TIMER_REM_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface bcd_timer_counter_if
  import bcd_timer_counter_pkg::*;
#(
  parameter int DIGITS = 2
);
  logic                        C_EN;
  logic                        LOAD;
  logic [DIGIT_W*DIGITS-1:0]   LIMIT;
  logic                        UP;
  logic [DIGIT_W*DIGITS-1:0]   D_OUT;
  logic                        C_OUT;
  logic                        DONE;
  logic                        LIMIT_ERR;
`ifdef BCD_TIMER_REM_EN
  logic [DIGIT_W*DIGITS-1:0]   REM_OUT;

  modport master (output C_EN, LOAD, LIMIT, UP,
                  input  D_OUT, C_OUT, DONE, LIMIT_ERR, REM_OUT);
  modport slave  (input  C_EN, LOAD, LIMIT, UP,
                  output D_OUT, C_OUT, DONE, LIMIT_ERR, REM_OUT);
`else
  modport master (output C_EN, LOAD, LIMIT, UP,
                  input  D_OUT, C_OUT, DONE, LIMIT_ERR);
  modport slave  (input  C_EN, LOAD, LIMIT, UP,
                  output D_OUT, C_OUT, DONE, LIMIT_ERR);
`endif
endinterface
`default_nettype wire

// File: rtl/bcd_timer_counter_digit_step.sv
`default_nettype none
// ============================================================================
// Module      : bcd_digit_step
// Description : One BCD digit of the ripple increment/decrement chain.
//               carry_in requests a step; carry_out requests a step of the
//               next digit (9->0 going up, 0->9 going down).
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_step
  import bcd_timer_counter_pkg::*;
(
  input  wire logic [DIGIT_W-1:0] digit,
  input  wire logic               up,
  input  wire logic               carry_in,
  output logic      [DIGIT_W-1:0] next_digit,
  output logic                    carry_out
);

  // Single-digit BCD step with wrap and carry/borrow generation.
  always_comb begin
    next_digit = digit;
    carry_out  = 1'b0;
    if (carry_in) begin
      if (up) begin
        if (digit >= MAX_DIGIT) begin
          next_digit = '0;
          carry_out  = 1'b1;
        end else begin
          next_digit = digit + 4'd1;
        end
      end else begin
        if (digit == '0) begin
          next_digit = MAX_DIGIT;
          carry_out  = 1'b1;
        end else begin
          next_digit = digit - 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_timer_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_timer_counter
// Description : N-digit BCD interval counter with programmable terminal,
//               up/down mode, registered carry pulse, sticky DONE for
//               one-shot builds and limit validation.
//               Optional macro BCD_TIMER_REM_EN adds REM_OUT (distance to
//               terminal) and its BCD subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_timer_counter
  import bcd_timer_counter_pkg::*;
#(
  parameter int DIGITS      = 2,
  parameter bit AUTO_RELOAD = 1'b1
)(
  input  wire logic              C_CLK,
  input  wire logic              RST,
  bcd_timer_counter_if.slave     bus
);

  localparam int BUS_W = DIGIT_W * DIGITS;

  state_t             r_state;
  logic [BUS_W-1:0]   r_limit;
  logic [BUS_W-1:0]   r_count;
  logic               r_cout;
  logic               r_done;
  logic               r_err;

  logic [BUS_W-1:0]   w_start;
  logic [BUS_W-1:0]   w_terminal;
  logic [BUS_W-1:0]   w_next;
  logic [BUS_W-1:0]   w_step_count;
  logic [DIGITS:0]    w_carry;
  logic               w_limit_ok;

  // Direction decides which end of the range is start and which is terminal.
  assign w_start    = bus.UP ? '0 : r_limit;
  assign w_terminal = bus.UP ? r_limit : '0;
  assign w_limit_ok = is_valid_bcd(MAX_BUS_W'(bus.LIMIT));

  assign w_carry[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_step u_step (
      .digit      (r_count[i*DIGIT_W +: DIGIT_W]),
      .up         (bus.UP),
      .carry_in   (w_carry[i]),
      .next_digit (w_next[i*DIGIT_W +: DIGIT_W]),
      .carry_out  (w_carry[i+1])
    );
  end

  // A ripple out of the top digit cannot occur while count stays inside
  // 0..limit; if it ever did, restart cleanly instead of wrapping.
  assign w_step_count = w_carry[DIGITS] ? w_start : w_next;

  // Control FSM: LOAD has priority over counting; registered outputs.
  always_ff @(posedge C_CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_limit <= '0;
      r_count <= '0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (bus.LOAD) begin
      r_cout <= 1'b0;
      if (w_limit_ok) begin
        r_limit <= bus.LIMIT;
        r_count <= bus.UP ? '0 : bus.LIMIT;
        r_err   <= 1'b0;
        r_done  <= 1'b0;
        r_state <= ST_RUN;
      end else begin
        r_err   <= 1'b1;
      end
    end else begin
      r_cout <= 1'b0;
      case (r_state)
        ST_RUN: begin
          if (bus.C_EN) begin
            if (r_count == w_terminal) begin
              r_count <= w_start;
              r_cout  <= 1'b1;
              if (!AUTO_RELOAD) begin
                r_state <= ST_STOP;
                r_done  <= 1'b1;
              end
            end else begin
              r_count <= w_step_count;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.D_OUT     = r_count;
  assign bus.C_OUT     = r_cout;
  assign bus.DONE      = r_done;
  assign bus.LIMIT_ERR = r_err;

`ifdef BCD_TIMER_REM_EN
  logic [BUS_W-1:0] w_rem_diff;

  // Digit-wise BCD subtract limit - count; count never exceeds limit.
  always_comb begin
    logic       borrow;
    logic [4:0] diff;
    borrow     = 1'b0;
    diff       = '0;
    w_rem_diff = '0;
    for (int i = 0; i < DIGITS; i++) begin
      diff = {1'b0, r_limit[i*DIGIT_W +: DIGIT_W]}
           - {1'b0, r_count[i*DIGIT_W +: DIGIT_W]}
           - {4'b0000, borrow};
      if (diff[4]) begin
        w_rem_diff[i*DIGIT_W +: DIGIT_W] = diff[3:0] + 4'd10;
        borrow = 1'b1;
      end else begin
        w_rem_diff[i*DIGIT_W +: DIGIT_W] = diff[3:0];
        borrow = 1'b0;
      end
    end
  end

  assign bus.REM_OUT = bus.UP ? w_rem_diff : r_count;
`endif

endmodule
`default_nettype wire
